// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults for the RAM-backed FIFO controller.
// The storage depth is derived from the RAM address width.
package ram_fifo_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_dp.sv
// Dual-port RAM with registered reads on both ports.
// The contents are cleared by the asynchronous reset.
module ram_dp #(
    parameter int CAM_DATA_WIDTH = 8,
    parameter int CAM_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      a_we,
    input  logic [CAM_ADDR_WIDTH-1:0] a_addr,
    input  logic [CAM_DATA_WIDTH-1:0] a_din,
    output logic [CAM_DATA_WIDTH-1:0] a_dout,
    input  logic                      b_we,
    input  logic [CAM_ADDR_WIDTH-1:0] b_addr,
    input  logic [CAM_DATA_WIDTH-1:0] b_din,
    output logic [CAM_DATA_WIDTH-1:0] b_dout
);

    localparam int DEPTH = 1 << CAM_ADDR_WIDTH;

    logic [DEPTH-1:0][CAM_DATA_WIDTH-1:0] mem;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem    <= '0;
            a_dout <= '0;
            b_dout <= '0;
        end else begin
            if (a_we) mem[a_addr] <= a_din;
            if (b_we) mem[b_addr] <= b_din;
            a_dout <= mem[a_addr];
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Stream FIFO built on ram_dp: port A writes, port B reads, and a
// 2-entry skid buffer hides the registered read so the output runs at full rate.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] count
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  inflight;
    logic [1:0]            ob_cnt;
    logic [DATA_WIDTH-1:0] ob0, ob1;
    logic [DATA_WIDTH-1:0] b_dout;
    logic [DATA_WIDTH-1:0] a_dout_unused;
    logic                  push, pop, rd_issue;

    assign s_ready = rstn & (ram_cnt != DEPTH_V) & ~flush;
    assign push    = s_valid & s_ready;
    assign m_valid = (ob_cnt != 2'd0);
    assign m_data  = ob0;
    assign pop     = m_valid & m_ready;

    // Issue only if the word still fits once it lands, counting the one in flight.
    assign rd_issue = (ram_cnt != '0) & ~flush &
                      ({1'b0, ob_cnt} + {2'b0, inflight} <= 3'd1 + {2'b0, pop});

    assign count = {1'b0, ram_cnt} + {{(ADDR_WIDTH+1){1'b0}}, inflight}
                 + {{ADDR_WIDTH{1'b0}}, ob_cnt};

    ram_dp #(
        .CAM_DATA_WIDTH(DATA_WIDTH),
        .CAM_ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rstn   (rstn),
        .a_we   (push),
        .a_addr (wr_ptr),
        .a_din  (s_data),
        .a_dout (a_dout_unused),
        .b_we   (1'b0),
        .b_addr (rd_ptr),
        .b_din  ({DATA_WIDTH{1'b0}}),
        .b_dout (b_dout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
            ram_cnt <= ram_cnt + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, rd_issue};
        end
    end

    // Skid buffer: inflight means b_dout carries a valid word this cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= 1'b0;
            ob_cnt   <= 2'd0;
            ob0      <= '0;
            ob1      <= '0;
        end else if (flush) begin
            inflight <= 1'b0;
            ob_cnt   <= 2'd0;
        end else begin
            inflight <= rd_issue;
            case ({pop, inflight})
                2'b10: begin
                    ob0    <= ob1;
                    ob_cnt <= ob_cnt - 2'd1;
                end
                2'b01: begin
                    if (ob_cnt == 2'd0) ob0 <= b_dout;
                    else                ob1 <= b_dout;
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b11: begin
                    if (ob_cnt == 2'd1) ob0 <= b_dout;
                    else begin
                        ob0 <= ob1;
                        ob1 <= b_dout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
